fft_peak_ctrl: RTL and testbench
================================

Name: fft_peak_ctrl

Overview:
- Frame sequencer and peak finder behind the FFT magnitude-squared stage.
- Consumes the streamed mag_sq/mag_valid samples and tracks the bin index within each FFT frame using a start-of-frame marker.
- Finds the largest magnitude inside a configurable bin window and presents {bin, magnitude, above-threshold} on a valid/ready output to the downstream tone/direction logic.
- Flags frame resynchronisation and results lost to output back-pressure.

Parameters:
W, 16, bit-width of the FFT real/imag components; magnitude width is 2W+1
NFFT, 1024, bins per frame (power of two)
MIN_BIN, 1, lowest bin considered, inclusive
MAX_BIN, 511, highest bin considered, inclusive (MIN_BIN <= MAX_BIN < NFFT)
IDXW, $clog2(NFFT), bin index width

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
enable  in  1  allows a new frame to start; sampled only at frame start
mag_valid  in  1  mag_sq sample valid this cycle
mag_sop  in  1  marks bin 0 of a frame; meaningful only with mag_valid
mag_sq  in  2W+1  unsigned magnitude squared
threshold  in  2W+1  unsigned detection threshold
peak_valid  out  1  result available
peak_ready  in  1  downstream accepts result
peak_bin  out  IDXW  bin index of the peak
peak_mag  out  2W+1  peak magnitude squared
peak_above  out  1  peak_mag >= threshold
frame_drop  out  1  one-cycle pulse: an unconsumed result was overwritten
sync_err  out  1  one-cycle pulse: mag_sop arrived mid-frame
busy  out  1  high while a frame is being accumulated

Behaviour:
- Reset (reset==0 at a clock edge):
  - State IDLE; bin counter, best_mag and best_bin cleared.
  - All outputs 0.
  - Reset mid-frame discards the partial frame and any pending result.
- States: IDLE, ACCUM. busy = (state==ACCUM).
- IDLE:
  - mag_valid && mag_sop && enable: process the sample as bin 0 and go to ACCUM.
  - Any other mag_valid is ignored.
  - If enable==0, the frame is ignored entirely, including its sop.
- ACCUM:
  - Each mag_valid advances the bin counter k.
  - enable changes have no effect until the frame ends.
- Accumulation:
  - Frame start initialises best_mag=0, best_bin=MIN_BIN.
  - Sample at bin k with MIN_BIN<=k<=MAX_BIN: if mag_sq > best_mag (strict, unsigned), then best_mag=mag_sq and best_bin=k.
  - Ties keep the lower index.
  - Samples outside the window are counted but not compared.
- Frame end (mag_valid at k==NFFT-1):
  - At the next edge, load peak_mag/peak_bin from the final best values, including that sample's comparison.
  - Load peak_above = (final peak_mag >= threshold), with threshold sampled on the end cycle.
  - Set peak_valid=1 and return to IDLE.
  - Latency: peak_valid rises 1 cycle after the last-bin sample.
  - A sop on the very next cycle is accepted (back-to-back frames, no gap).
- mag_sop with mag_valid while in ACCUM:
  - sync_err pulses for one cycle.
  - Accumulators restart with this sample as bin 0; stay in ACCUM.
  - No result is produced for the aborted frame.
- mag_valid gaps: allowed anywhere within a frame; the counter holds.
- Output handshake:
  - peak_* stays stable while peak_valid && !peak_ready.
  - On peak_valid && peak_ready, peak_valid clears next cycle unless a new result loads on that same edge; then peak_valid stays 1 with the new data and there is no frame_drop.
  - A new result loading while peak_valid && !peak_ready overwrites the old one and frame_drop pulses one cycle.
- All-zero window: result is peak_mag=0, peak_bin=MIN_BIN, and peak_above = (threshold==0).
- Counter wraps only via frame end; no modular arithmetic on k beyond NFFT-1.

Test Plan:
(Bench uses NFFT=16, MIN_BIN=1, MAX_BIN=7, W=16.)
- Single frame, bins 0..15 = 0 except bin3=500, bin10=9000, threshold=400, peak_ready=1 -> peak_valid for 1 cycle, 1 cycle after bin 15; peak_bin=3, peak_mag=500, peak_above=1 (bin10 ignored, outside window).
- Ties and gaps: bin2=bin5=700, with mag_valid low for 3 cycles between bins 4 and 5, threshold=800 -> peak_bin=2, peak_mag=700, peak_above=0.
- Back-pressure: peak_ready=0, two back-to-back frames with peaks (bin4=100) then (bin6=200) -> frame_drop pulses once at the second load; result shows bin 6/200, held stable until peak_ready=1, then peak_valid=0 next cycle.
- Resync: sop re-asserted at bin 9 of a frame -> sync_err pulse, no result for the aborted frame; the following 16 samples produce one correct result.
- Enable/reset: enable=0 at sop -> no result and busy=0 for the whole frame. Then enable=1 and reset=0 at bin 8 of a frame -> all outputs 0 and IDLE; next full frame is reported normally.

Source files
------------

// File: rtl/fft_peak_ctrl_if.sv
// Magnitude stream in, peak result out: the bundle between the FFT magnitude
// stage, fft_peak_ctrl and the downstream tone/direction logic.
interface fft_peak_ctrl_if #(
   parameter int unsigned W    = 16,
   parameter int unsigned IDXW = 10
);
   logic            mag_valid;
   logic            mag_sop;
   logic [2*W:0]    mag_sq;
   logic            peak_valid;
   logic            peak_ready;
   logic [IDXW-1:0] peak_bin;
   logic [2*W:0]    peak_mag;
   logic            peak_above;

   modport master (
      output mag_valid, mag_sop, mag_sq, peak_ready,
      input  peak_valid, peak_bin, peak_mag, peak_above
   );

   modport slave (
      input  mag_valid, mag_sop, mag_sq, peak_ready,
      output peak_valid, peak_bin, peak_mag, peak_above
   );
endinterface

// File: rtl/fft_peak_ctrl.sv
// FFT frame sequencer and windowed peak finder; reports {bin, mag, above}
// on a valid/ready result port, flags resyncs and overwritten results.
module fft_peak_ctrl #(
   parameter int unsigned W       = 16,
   parameter int unsigned NFFT    = 1024,
   parameter int unsigned MIN_BIN = 1,
   parameter int unsigned MAX_BIN = 511,
   parameter int unsigned IDXW    = $clog2(NFFT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [2*W:0]  threshold,
   fft_peak_ctrl_if.slave pk,
   output logic          frame_drop,
   output logic          sync_err,
   output logic          busy
);
   localparam int unsigned MW = 2*W + 1;
   localparam logic [IDXW-1:0] MIN_K  = IDXW'(MIN_BIN);
   localparam logic [IDXW-1:0] MAX_K  = IDXW'(MAX_BIN);
   localparam logic [IDXW-1:0] LAST_K = IDXW'(NFFT - 1);

   typedef enum logic {IDLE, ACCUM} state_e;

   state_e          state_q, state_d;
   logic [IDXW-1:0] k_q, k_d, k_cur;
   logic [IDXW-1:0] best_bin_q, best_bin_d, base_bin;
   logic [MW-1:0]   best_mag_q, best_mag_d, base_mag;
   logic [IDXW-1:0] peak_bin_q, peak_bin_d;
   logic [MW-1:0]   peak_mag_q, peak_mag_d;
   logic            peak_valid_q, peak_valid_d;
   logic            peak_above_q, peak_above_d;
   logic            drop_q, drop_d;
   logic            sync_q, sync_d;
   logic            start, resync, accept, last, upd;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ACCUM;
         ACCUM:   if (last)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == ACCUM);
   end

   // A start (fresh or resync) folds bin 0 into freshly initialised
   // accumulators in the same cycle, so k/best see "base" values, not the _q.
   always_comb begin
      start    = pk.mag_valid && pk.mag_sop && (state_q == ACCUM || enable);
      resync   = pk.mag_valid && pk.mag_sop && (state_q == ACCUM);
      accept   = pk.mag_valid && (state_q == ACCUM || start);
      k_cur    = start ? '0 : k_q;
      base_mag = start ? '0 : best_mag_q;
      base_bin = start ? MIN_K : best_bin_q;
      upd      = accept && (k_cur >= MIN_K) && (k_cur <= MAX_K) && (pk.mag_sq > base_mag);
      last     = accept && (k_cur == LAST_K);

      k_d        = k_q;
      best_mag_d = best_mag_q;
      best_bin_d = best_bin_q;
      if (accept) begin
         k_d        = last ? '0 : k_cur + 1'b1;
         best_mag_d = upd ? pk.mag_sq : base_mag;
         best_bin_d = upd ? k_cur : base_bin;
      end

      peak_valid_d = last || (peak_valid_q && !pk.peak_ready);
      drop_d       = last && peak_valid_q && !pk.peak_ready;
      sync_d       = resync;
      peak_mag_d   = last ? best_mag_d : peak_mag_q;
      peak_bin_d   = last ? best_bin_d : peak_bin_q;
      peak_above_d = last ? (best_mag_d >= threshold) : peak_above_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         k_q          <= '0;
         best_mag_q   <= '0;
         best_bin_q   <= '0;
         peak_valid_q <= 1'b0;
         peak_mag_q   <= '0;
         peak_bin_q   <= '0;
         peak_above_q <= 1'b0;
         drop_q       <= 1'b0;
         sync_q       <= 1'b0;
      end else begin
         k_q          <= k_d;
         best_mag_q   <= best_mag_d;
         best_bin_q   <= best_bin_d;
         peak_valid_q <= peak_valid_d;
         peak_mag_q   <= peak_mag_d;
         peak_bin_q   <= peak_bin_d;
         peak_above_q <= peak_above_d;
         drop_q       <= drop_d;
         sync_q       <= sync_d;
      end
   end

   assign pk.peak_valid = peak_valid_q;
   assign pk.peak_bin   = peak_bin_q;
   assign pk.peak_mag   = peak_mag_q;
   assign pk.peak_above = peak_above_q;
   assign frame_drop    = drop_q;
   assign sync_err      = sync_q;
endmodule

// File: tb/tb_fft_peak_ctrl.sv
// Directed bench for fft_peak_ctrl with NFFT=16, window bins 1..7.
module tb_fft_peak_ctrl;
   localparam int unsigned W    = 16;
   localparam int unsigned NFFT = 16;
   localparam int unsigned IDXW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [2*W:0]  threshold;
   logic          frame_drop, sync_err, busy;

   int nvec = 0;
   int nerr = 0;

   fft_peak_ctrl_if #(.W(W), .IDXW(IDXW)) ifc ();

   fft_peak_ctrl #(
      .W(W), .NFFT(NFFT), .MIN_BIN(1), .MAX_BIN(7), .IDXW(IDXW)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
      .pk(ifc.slave), .frame_drop(frame_drop), .sync_err(sync_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          b0;
      logic [32:0] v0;
      int          b1;
      logic [32:0] v1;
      int          gap_at;
      logic [32:0] thr;
      logic [3:0]  ebin;
      logic [32:0] emag;
      logic        eab;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic put(input logic [32:0] v, input logic sop);
      ifc.mag_valid = 1'b1;
      ifc.mag_sop   = sop;
      ifc.mag_sq    = v;
      @(posedge clk); #1;
      ifc.mag_valid = 1'b0;
      ifc.mag_sop   = 1'b0;
      ifc.mag_sq    = '0;
   endtask

   task automatic idle(input int n);
      ifc.mag_valid = 1'b0;
      ifc.mag_sop   = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      tbl[0] = '{3, 33'd500, 10, 33'd9000, -1, 33'd400, 4'd3, 33'd500, 1'b1};
      tbl[1] = '{-1, 33'd0, -1, 33'd0, -1, 33'd0, 4'd1, 33'd0, 1'b1};
      tbl[2] = '{-1, 33'd0, -1, 33'd0, -1, 33'd1, 4'd1, 33'd0, 1'b0};
      tbl[3] = '{0, 33'd1000, 7, 33'd50, -1, 33'd50, 4'd7, 33'd50, 1'b1};
      tbl[4] = '{8, 33'd999, 1, 33'd3, -1, 33'd4, 4'd1, 33'd3, 1'b0};
      tbl[5] = '{2, 33'd700, 5, 33'd700, 5, 33'd800, 4'd2, 33'd700, 1'b0};
      tbl[6] = '{6, 33'h1_FFFF_FFFE, 15, 33'h1_FFFF_FFFF, -1, 33'h1_FFFF_FFFF,
                 4'd6, 33'h1_FFFF_FFFE, 1'b0};

      reset = 1'b0; enable = 1'b1; threshold = '0;
      ifc.mag_valid = 1'b0; ifc.mag_sop = 1'b0; ifc.mag_sq = '0; ifc.peak_ready = 1'b1;
      idle(2);
      chk("rst_valid", 64'(ifc.peak_valid), 64'd0);
      chk("rst_bin",   64'(ifc.peak_bin),   64'd0);
      chk("rst_mag",   64'(ifc.peak_mag),   64'd0);
      chk("rst_above", 64'(ifc.peak_above), 64'd0);
      chk("rst_busy",  64'(busy),           64'd0);
      chk("rst_drop",  64'(frame_drop),     64'd0);
      chk("rst_sync",  64'(sync_err),       64'd0);
      reset = 1'b1;
      idle(1);

      // table-driven single frames, peak_ready held high
      for (int v = 0; v < 7; v++) begin
         threshold = tbl[v].thr;
         for (int i = 0; i < 16; i++) begin
            logic [32:0] val;
            if (i == tbl[v].gap_at) begin
               idle(3);
               chk($sformatf("v%0d_gap_busy", v), 64'(busy), 64'd1);
            end
            val = (i == tbl[v].b0) ? tbl[v].v0 : (i == tbl[v].b1) ? tbl[v].v1 : 33'd0;
            put(val, i == 0);
            if (i == 0)  chk($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
            if (i == 14) chk($sformatf("v%0d_early", v), 64'(ifc.peak_valid), 64'd0);
         end
         chk($sformatf("v%0d_valid", v), 64'(ifc.peak_valid), 64'd1);
         chk($sformatf("v%0d_bin", v),   64'(ifc.peak_bin),   64'(tbl[v].ebin));
         chk($sformatf("v%0d_mag", v),   64'(ifc.peak_mag),   64'(tbl[v].emag));
         chk($sformatf("v%0d_above", v), 64'(ifc.peak_above), 64'(tbl[v].eab));
         chk($sformatf("v%0d_idle", v),  64'(busy),           64'd0);
         idle(1);
         chk($sformatf("v%0d_pulse", v), 64'(ifc.peak_valid), 64'd0);
      end

      // back-pressure: two back-to-back frames, second overwrites first
      threshold = '0; ifc.peak_ready = 1'b0;
      for (int i = 0; i < 16; i++) put((i == 4) ? 33'd100 : 33'd0, i == 0);
      chk("bp1_valid", 64'(ifc.peak_valid), 64'd1);
      chk("bp1_bin",   64'(ifc.peak_bin),   64'd4);
      chk("bp1_drop",  64'(frame_drop),     64'd0);
      for (int i = 0; i < 16; i++) begin
         put((i == 6) ? 33'd200 : 33'd0, i == 0);
         if (i == 7) begin
            chk("bp_hold_bin", 64'(ifc.peak_bin), 64'd4);
            chk("bp_hold_mag", 64'(ifc.peak_mag), 64'd100);
         end
      end
      chk("bp2_valid", 64'(ifc.peak_valid), 64'd1);
      chk("bp2_bin",   64'(ifc.peak_bin),   64'd6);
      chk("bp2_mag",   64'(ifc.peak_mag),   64'd200);
      chk("bp2_drop",  64'(frame_drop),     64'd1);
      idle(1);
      chk("bp_drop_end", 64'(frame_drop),     64'd0);
      chk("bp_stall_v",  64'(ifc.peak_valid), 64'd1);
      idle(2);
      chk("bp_stall_b",  64'(ifc.peak_bin),   64'd6);
      chk("bp_stall_m",  64'(ifc.peak_mag),   64'd200);
      ifc.peak_ready = 1'b1;
      idle(1);
      chk("bp_release",  64'(ifc.peak_valid), 64'd0);

      // resync: sop again at bin 9 aborts the first frame
      for (int i = 0; i < 9; i++) put((i == 2) ? 33'd300 : 33'd0, i == 0);
      put(33'd0, 1'b1);
      chk("rs_sync",  64'(sync_err),       64'd1);
      chk("rs_busy",  64'(busy),           64'd1);
      chk("rs_nores", 64'(ifc.peak_valid), 64'd0);
      for (int i = 1; i < 16; i++) begin
         put((i == 5) ? 33'd77 : 33'd0, 1'b0);
         if (i == 1)  chk("rs_sync_end", 64'(sync_err), 64'd0);
         if (i == 9)  chk("rs_old_end",  64'(ifc.peak_valid), 64'd0);
         if (i == 14) chk("rs_early",    64'(ifc.peak_valid), 64'd0);
      end
      chk("rs_valid", 64'(ifc.peak_valid), 64'd1);
      chk("rs_bin",   64'(ifc.peak_bin),   64'd5);
      chk("rs_mag",   64'(ifc.peak_mag),   64'd77);
      idle(1);

      // enable low at sop: whole frame ignored
      enable = 1'b0;
      for (int i = 0; i < 16; i++) begin
         put((i == 3) ? 33'd1000 : 33'd0, i == 0);
         if (i == 0 || i == 15) chk($sformatf("en0_busy%0d", i), 64'(busy), 64'd0);
      end
      idle(1);
      chk("en0_nores", 64'(ifc.peak_valid), 64'd0);

      // reset at bin 8 of an accepted frame
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         put((i == 2) ? 33'd111 : 33'd0, i == 0);
         if (i == 0) enable = 1'b0;
      end
      reset = 1'b0;
      put(33'd0, 1'b0);
      chk("mr_busy",  64'(busy),           64'd0);
      chk("mr_valid", 64'(ifc.peak_valid), 64'd0);
      chk("mr_bin",   64'(ifc.peak_bin),   64'd0);
      chk("mr_mag",   64'(ifc.peak_mag),   64'd0);
      reset = 1'b1; enable = 1'b1;
      for (int i = 9; i < 16; i++) put(33'd0, 1'b0);
      chk("mr_tail_busy", 64'(busy), 64'd0);
      idle(1);
      chk("mr_tail_nores", 64'(ifc.peak_valid), 64'd0);

      // next full frame after reset, enable dropped mid-frame
      threshold = 33'd50;
      for (int i = 0; i < 16; i++) begin
         put((i == 4) ? 33'd42 : 33'd0, i == 0);
         if (i == 3)  enable = 1'b0;
         if (i == 10) enable = 1'b1;
      end
      chk("pr_valid", 64'(ifc.peak_valid), 64'd1);
      chk("pr_bin",   64'(ifc.peak_bin),   64'd4);
      chk("pr_mag",   64'(ifc.peak_mag),   64'd42);
      chk("pr_above", 64'(ifc.peak_above), 64'd0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
